cpu_ce_gen: RTL
===============

# cpu_ce_gen

Parametrised CPU clock-enable generator with up to NUM_MODES selectable speed modes, per-mode contention wait gating and glitch-free mode handover. It replaces the fixed two-mode (native / ZX-real) enable logic in the top level. Its outputs drive T80pa `CEN_p`/`CEN_n` directly. All divider state runs on `clk_sys`; no derived clocks.

## Interface
Parameters:
- DIV_WIDTH, 6, width of each per-mode period value
- NUM_MODES, 4, number of speed modes (≥2)
- GUARD_CYCLES, 3, idle `clk_sys` cycles inserted between modes on a switch

Ports:
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- mode_sel  in  $clog2(NUM_MODES)  requested mode
- mode_div  in  NUM_MODES*DIV_WIDTH  per-mode period P in `clk_sys` cycles; mode i at bits [i*DIV_WIDTH +: DIV_WIDTH]
- cont_mask  in  NUM_MODES  1 = mode honours wait_req; 0 = mode never stalls
- wait_req  in  1  contention request (RAM/IO wait), level
- ce_cpu_p  out  1  CPU positive-phase enable pulse
- ce_cpu_n  out  1  CPU negative-phase enable pulse
- cpu_en  out  1  current period not stalled
- active_mode  out  $clog2(NUM_MODES)  mode currently generating pulses
- switching  out  1  high from switch detection until the new mode's first period starts

## Operation
- Latched period `p_cur` = max(mode_div[active_mode], 2). Latched only at mode load; live changes to mode_div take effect at the next load.
- Counter `cnt` runs 0..p_cur-1 and wraps.
- Raw phases: p at cnt==0, n at cnt==p_cur/2 (floor).
- At cnt==0: cpu_en <= ~(wait_req & cont_mask[active_mode]).
- The value applies to the whole period: ce_cpu_p = p & cpu_en; ce_cpu_n = n & cpu_en.
- State machine:
  - RUN: normal pulse generation. If mode_sel != active_mode → DRAIN.
  - DRAIN: continue counting and emitting until cnt==p_cur-1, so the period's n pulse is never cut. Then → GUARD with guard counter = GUARD_CYCLES. No pulses emitted.
  - GUARD: decrement each cycle. At 0: active_mode <= mode_sel (latest value), latch p_cur, cnt <= 0, cpu_en <= 1, → RUN.
- If mode_sel returns to active_mode during DRAIN, the switch still completes, reloading the same mode.
- wait_req is ignored outside the cnt==0 sample, and during DRAIN/GUARD.

## Timing
- All outputs are registered. A pulse is asserted the cycle after the counter match and lasts exactly 1 cycle.
- ce_cpu_p and ce_cpu_n are never high in the same cycle. ce_cpu_p to ce_cpu_n separation = floor(P/2) cycles.
- Reset values:
  - ce_cpu_p=0, ce_cpu_n=0, cpu_en=1, switching=0
  - active_mode=mode_sel sampled at reset, cnt=0, state RUN
- First ce_cpu_p is emitted 1 cycle after reset deasserts.
- Reset mid-DRAIN/GUARD aborts the switch immediately, with no partial pulse.
- Switch latency: (remaining cycles of current period) + GUARD_CYCLES + 1 cycle to the new first ce_cpu_p.
- switching rises the cycle after the mismatch is seen and falls together with the new first ce_cpu_p.
- wait_req sampled high at cnt==0 suppresses exactly one period's p and n pulses. Release is seen only at the next cnt==0.

## Configuration
- CPU_CE_CONTENTION_EN defined: cont_mask and wait_req are honoured as above.
- Not defined: wait_req and cont_mask are unused and cpu_en is constant 1. Pulse timing and mode switching are otherwise identical.

## Structure
- Package cpu_ce_pkg holds:
  - state enum {RUN, DRAIN, GUARD}
  - MIN_DIV = 2
  - a function extracting and clamping one mode's period from the flattened mode_div vector
- Sub-module ce_divider contains the counter and phase-pulse generation. Its inputs are the period, a run enable and a load strobe.
- The top-level block keeps the state machine, the guard counter and contention gating.

## Test plan
- mode_div={27,16}, mode_sel=0, no wait → ce_cpu_p every 16 cycles, ce_cpu_n 8 cycles after each; first ce_cpu_p 1 cycle after reset.
- Mode 1 (P=27) → ce_cpu_n 13 cycles after ce_cpu_p, period 27.
- Mode 0, cont_mask=1, wait_req high across one cnt==0 → exactly one p/n pair missing, cpu_en low 16 cycles; with the macro undefined, no pulse missing.
- Switch 0→1 at cnt==3: last old ce_cpu_n still emitted at its position, then 3 idle cycles; new first ce_cpu_p 12+3+1 cycles after the switch was seen; switching high over that span.
- mode_sel toggles 0→1→2 during GUARD → mode 2 loaded; no pulse during GUARD.
- mode_div=0 → clamped to P=2, alternating p/n every cycle. Reset during DRAIN → outputs 0 next cycle, restart in sampled mode_sel.

Source files
------------

// File: rtl/cpu_ce_pkg.sv
// Shared types and helpers for the CPU clock-enable generator.
package cpu_ce_pkg;

  typedef enum logic [1:0] {RUN, DRAIN, GUARD} ce_state_e;

  localparam int MIN_DIV  = 2;
  localparam int FLAT_MAX = 512;

  // Pull mode idx's period out of the flattened vector and clamp it to MIN_DIV.
  function automatic logic [31:0] mode_period(input logic [FLAT_MAX-1:0] flat,
                                              input int idx, input int width);
    logic [31:0] r;
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    r    = 32'(flat >> (idx * width)) & mask;
    return (r < 32'(MIN_DIV)) ? 32'(MIN_DIV) : r;
  endfunction

endpackage

// File: rtl/ce_divider.sv
// Period counter for cpu_ce_gen: raw p/n phase matches and end-of-period flag.
module ce_divider #(
  parameter int DIV_WIDTH = 6
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 run,
  input  logic                 load,
  output logic                 p_hit,
  output logic                 n_hit,
  output logic                 last_hit
);

  logic [DIV_WIDTH-1:0] p_cur;
  logic [DIV_WIDTH-1:0] cnt;

  // The load cycle itself stands in for cnt==0 (its p pulse is issued by the
  // parent), so the counter resumes at 1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      p_cur <= period;
      cnt   <= '0;
    end else if (load) begin
      p_cur <= period;
      cnt   <= DIV_WIDTH'(1);
    end else if (run) begin
      cnt   <= last_hit ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

  assign p_hit    = (cnt == '0);
  assign n_hit    = (cnt == (p_cur >> 1));
  assign last_hit = (cnt == p_cur - DIV_WIDTH'(1));

endmodule

// File: rtl/cpu_ce_gen.sv
// CPU clock-enable generator: multi-mode divider with drain/guard mode handover.
// Optional contention gating enabled by defining CPU_CE_CONTENTION_EN.
module cpu_ce_gen
  import cpu_ce_pkg::*;
#(
  parameter int DIV_WIDTH    = 6,
  parameter int NUM_MODES    = 4,
  parameter int GUARD_CYCLES = 3
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic [$clog2(NUM_MODES)-1:0]   mode_sel,
  input  logic [NUM_MODES*DIV_WIDTH-1:0] mode_div,
  input  logic [NUM_MODES-1:0]           cont_mask,
  input  logic                           wait_req,
  output logic                           ce_cpu_p,
  output logic                           ce_cpu_n,
  output logic                           cpu_en,
  output logic [$clog2(NUM_MODES)-1:0]   active_mode,
  output logic                           switching
);

  localparam int SEL_W = $clog2(NUM_MODES);
  localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  ce_state_e            state, state_nx;
  logic [GW-1:0]        gcnt, gcnt_nx;
  logic [DIV_WIDTH-1:0] sel_period;
  logic                 p_hit, n_hit, last_hit;
  logic                 guard_done, mismatch, stall;
  int                   sel_idx;

  always_comb begin
    sel_idx = int'(mode_sel);
    if (sel_idx >= NUM_MODES) sel_idx = 0;
  end

  assign sel_period = DIV_WIDTH'(mode_period(FLAT_MAX'(mode_div), sel_idx, DIV_WIDTH));
  assign guard_done = (state == GUARD) && (gcnt == '0);
  assign mismatch   = (mode_sel != active_mode);

`ifdef CPU_CE_CONTENTION_EN
  logic cont_bit;
  always_comb begin
    cont_bit = 1'b0;
    for (int i = 0; i < NUM_MODES; i++)
      if (active_mode == SEL_W'(i)) cont_bit = cont_mask[i];
  end
  assign stall = wait_req & cont_bit;
`else
  logic unused_cont;
  assign unused_cont = wait_req ^ (^cont_mask);
  assign stall       = 1'b0;
`endif

  ce_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .period   (sel_period),
    .run      (state != GUARD),
    .load     (guard_done),
    .p_hit    (p_hit),
    .n_hit    (n_hit),
    .last_hit (last_hit)
  );

  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    case (state)
      RUN: if (mismatch) begin
        // A mismatch on the last count has nothing left to drain.
        if (last_hit) begin
          state_nx = GUARD;
          gcnt_nx  = GW'(GUARD_CYCLES - 1);
        end else begin
          state_nx = DRAIN;
        end
      end
      DRAIN: if (last_hit) begin
        state_nx = GUARD;
        gcnt_nx  = GW'(GUARD_CYCLES - 1);
      end
      GUARD: begin
        if (gcnt == '0) state_nx = RUN;
        else            gcnt_nx  = gcnt - GW'(1);
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= RUN;
      gcnt        <= '0;
      active_mode <= mode_sel;
      ce_cpu_p    <= 1'b0;
      ce_cpu_n    <= 1'b0;
      cpu_en      <= 1'b1;
      switching   <= 1'b0;
    end else begin
      state    <= state_nx;
      gcnt     <= gcnt_nx;
      ce_cpu_p <= guard_done | ((state == RUN) & p_hit & ~stall);
      ce_cpu_n <= (state != GUARD) & n_hit & cpu_en;
      if (guard_done) begin
        active_mode <= mode_sel;
        cpu_en      <= 1'b1;
        switching   <= 1'b0;
      end else begin
        if ((state == RUN) && p_hit) cpu_en    <= ~stall;
        if ((state == RUN) && mismatch) switching <= 1'b1;
      end
    end
  end

endmodule
